// File: rtl/alu_ccr_stage.sv
// rtl/alu_ccr_stage.sv - ALU writeback queue and condition-code register stage
module alu_ccr_stage #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_VALID,
  output logic         out_READY,
  input  logic [N-1:0] in_RES,
  input  logic [4:0]   in_XNZVC,
  input  logic [4:0]   in_MASK,
  input  logic         in_ZSTICKY,
  input  logic         in_WEN,
  input  logic [3:0]   in_DST,
  input  logic         in_CCR_LOAD,
  input  logic [4:0]   in_CCR_DATA,
  output logic [4:0]   out_CCR,
  output logic         out_X,
  output logic         out_WB_VALID,
  input  logic         in_WB_READY,
  output logic [N-1:0] out_WB_DATA,
  output logic [3:0]   out_WB_DST
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    r_ccr;
  logic [N-1:0]  r_data [DEPTH];
  logic [3:0]    r_dst  [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic [4:0] w_ccr_next;

  // Ready depends only on local occupancy so writeback stalls never reach the ALU combinationally.
  assign out_READY    = reset & (r_count < FULL);
  assign w_accept     = in_VALID & out_READY;
  assign w_push       = w_accept & in_WEN;
  assign out_WB_VALID = (r_count != '0);
  assign w_pop        = out_WB_VALID & in_WB_READY;

  assign out_CCR     = r_ccr;
  assign out_X       = r_ccr[4];
  assign out_WB_DATA = r_data[r_rptr];
  assign out_WB_DST  = r_dst[r_rptr];

  always_comb begin
    w_ccr_next = r_ccr;
    if (w_accept) begin
      for (int i = 0; i < 5; i++) begin
        if (in_MASK[i]) w_ccr_next[i] = in_XNZVC[i];
      end
      // Extended ops only ever clear Z so a multi-word result is zero only if every word was.
      if (in_MASK[2] && in_ZSTICKY) w_ccr_next[2] = r_ccr[2] & in_XNZVC[2];
    end
    if (in_CCR_LOAD) w_ccr_next = in_CCR_DATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ccr   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_dst[i]  <= '0;
      end
    end else begin
      r_ccr <= w_ccr_next;
      if (w_push) begin
        r_data[r_wptr] <= in_RES;
        r_dst[r_wptr]  <= in_DST;
        r_wptr         <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
